// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared types, FU codes and helpers for the reservation station
package types_pkg;

  localparam int PREG_W = 7;
  localparam int AGE_W  = 3;
  localparam int OPC_W  = 7;
  localparam int XLEN   = 32;
  localparam int ROB_W  = 5;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_BR  = 2'd1;
  localparam logic [1:0] FU_MEM = 2'd2;

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [XLEN-1:0]   pc;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] pr1;
    logic              pr1_ready;
    logic [PREG_W-1:0] pr2;
    logic              pr2_ready;
    logic [XLEN-1:0]   imm;
    logic [ROB_W-1:0]  rob_index;
  } dispatch_pipeline_data;

  typedef struct packed {
    logic              valid;
    logic [1:0]        fu;
    logic [AGE_W-1:0]  age;
    logic [OPC_W-1:0]  opcode;
    logic [XLEN-1:0]   pc;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] pr1;
    logic              pr1_ready;
    logic [PREG_W-1:0] pr2;
    logic              pr2_ready;
    logic [XLEN-1:0]   imm;
    logic [ROB_W-1:0]  rob_index;
  } rs_data;

  // p0 is hard-wired ready; a same-cycle broadcast also counts on insert.
  function automatic logic operand_ready(input logic [PREG_W-1:0] pr, input logic rdy,
                                         input logic wb_valid, input logic [PREG_W-1:0] wb_prd);
    return rdy || (pr == '0) || (wb_valid && (pr == wb_prd));
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - dispatch, wakeup, flush and issue signals of the reservation station
interface reservation_station_if;
  import types_pkg::*;

  logic                  disp_valid;
  logic [1:0]            disp_fu;
  dispatch_pipeline_data disp_data;
  logic                  disp_ready;
  logic                  wb_valid;
  logic [PREG_W-1:0]     wb_prd;
  logic                  flush;
  logic                  issue_valid;
  logic                  issue_ready;
  rs_data                issue_data;
  logic                  full;

  modport master (
    output disp_valid, disp_fu, disp_data, wb_valid, wb_prd, flush, issue_ready,
    input  disp_ready, issue_valid, issue_data, full
  );

  modport slave (
    input  disp_valid, disp_fu, disp_data, wb_valid, wb_prd, flush, issue_ready,
    output disp_ready, issue_valid, issue_data, full
  );

endinterface

// File: rtl/rs_select.sv
// rtl/rs_select.sv - oldest-ready picker: highest age wins, ties go to the lowest index
module rs_select
  import types_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            eligible_i,
  input  logic [DEPTH-1:0][AGE_W-1:0] ages_i,
  output logic [DEPTH-1:0]            grant_o,
  output logic                        valid_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AGE_W-1:0] best_age;
  logic [IW-1:0]    best_idx;
  logic             found;

  always_comb begin
    best_age = '0;
    best_idx = '0;
    found    = 1'b0;
    grant_o  = '0;
    // Strict greater-than keeps the earlier index on equal ages.
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible_i[i] && (!found || (ages_i[i] > best_age))) begin
        found    = 1'b1;
        best_age = ages_i[i];
        best_idx = IW'(i);
      end
    end
    if (found) grant_o[best_idx] = 1'b1;
    valid_o = found;
  end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - FU-filtered reservation station with wakeup, aging and oldest-ready issue
module reservation_station
  import types_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter logic [1:0] FU_ID = 2'd0
) (
  input logic                  clk,
  input logic                  reset,
  reservation_station_if.slave rs
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_data                      entries_q [DEPTH];
  rs_data                      entries_d [DEPTH];
  rs_data                      new_entry;
  rs_data                      issue_data_w;
  logic [DEPTH-1:0]            valid_vec;
  logic [DEPTH-1:0]            eligible;
  logic [DEPTH-1:0][AGE_W-1:0] ages;
  logic [DEPTH-1:0]            grant;
  logic                        sel_valid;
  logic                        full_w;
  logic                        issue_valid_w;
  logic                        accept;
  logic                        fire;
  logic [IW-1:0]               free_idx;
  logic                        free_found;

  always_comb begin
    valid_vec = '0;
    eligible  = '0;
    ages      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      eligible[i]  = entries_q[i].valid && entries_q[i].pr1_ready && entries_q[i].pr2_ready;
      ages[i]      = entries_q[i].age;
    end
  end

  rs_select #(.DEPTH(DEPTH)) u_select (
    .eligible_i (eligible),
    .ages_i     (ages),
    .grant_o    (grant),
    .valid_o    (sel_valid)
  );

  // Outputs are forced to their idle values while reset is held.
  assign full_w        = (&valid_vec) && !reset;
  assign issue_valid_w = sel_valid && !reset;
  assign accept        = rs.disp_valid && !full_w && (rs.disp_fu == FU_ID) && !rs.flush;
  assign fire          = issue_valid_w && rs.issue_ready;

  always_comb begin
    issue_data_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_valid_w && grant[i]) issue_data_w = entries_q[i];
    end
  end

  assign rs.full        = full_w;
  assign rs.disp_ready  = !full_w;
  assign rs.issue_valid = issue_valid_w;
  assign rs.issue_data  = issue_data_w;

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!entries_q[i].valid && !free_found) begin
        free_idx   = IW'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.fu        = rs.disp_fu;
    new_entry.opcode    = rs.disp_data.opcode;
    new_entry.pc        = rs.disp_data.pc;
    new_entry.prd       = rs.disp_data.prd;
    new_entry.pr1       = rs.disp_data.pr1;
    new_entry.pr2       = rs.disp_data.pr2;
    new_entry.imm       = rs.disp_data.imm;
    new_entry.rob_index = rs.disp_data.rob_index;
    new_entry.pr1_ready = operand_ready(rs.disp_data.pr1, rs.disp_data.pr1_ready,
                                        rs.wb_valid, rs.wb_prd);
    new_entry.pr2_ready = operand_ready(rs.disp_data.pr2, rs.disp_data.pr2_ready,
                                        rs.wb_valid, rs.wb_prd);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        if (rs.wb_valid && (entries_q[i].pr1 == rs.wb_prd)) entries_d[i].pr1_ready = 1'b1;
        if (rs.wb_valid && (entries_q[i].pr2 == rs.wb_prd)) entries_d[i].pr2_ready = 1'b1;
        if (accept && (entries_q[i].age != AGE_MAX)) entries_d[i].age = entries_q[i].age + 3'd1;
      end
      // Issue beats a same-cycle wakeup; flush beats everything.
      if (fire && grant[i]) entries_d[i].valid = 1'b0;
      if (rs.flush)         entries_d[i].valid = 1'b0;
    end
    if (accept) entries_d[free_idx] = new_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - randomized and directed bench against a slot-level reference model
module tb_reservation_station;
  import types_pkg::*;

  localparam int         DEPTH = 8;
  localparam logic [1:0] FU_ID = FU_ALU;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reservation_station_if rs_if();

  reservation_station #(.DEPTH(DEPTH), .FU_ID(FU_ID)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rs_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: one record per slot, age kept as an unbounded-style int capped at 7.
  typedef struct {
    bit                    v;
    int                    age;
    dispatch_pipeline_data d;
  } m_ent_t;

  m_ent_t m [DEPTH];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].v) c++;
    return c;
  endfunction

  function automatic int m_pick();
    int best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].d.pr1_ready && m[i].d.pr2_ready)
        if (best < 0 || m[i].age > m[best].age) best = i;
    end
    return best;
  endfunction

  function automatic rs_data m_view(input int i);
    rs_data r = '0;
    r.valid     = 1'b1;
    r.fu        = FU_ID;
    r.age       = 3'(m[i].age);
    r.opcode    = m[i].d.opcode;
    r.pc        = m[i].d.pc;
    r.prd       = m[i].d.prd;
    r.pr1       = m[i].d.pr1;
    r.pr1_ready = m[i].d.pr1_ready;
    r.pr2       = m[i].d.pr2;
    r.pr2_ready = m[i].d.pr2_ready;
    r.imm       = m[i].d.imm;
    r.rob_index = m[i].d.rob_index;
    return r;
  endfunction

  function automatic dispatch_pipeline_data rand_instr();
    dispatch_pipeline_data d;
    d.opcode    = 7'($urandom);
    d.pc        = $urandom;
    d.prd       = 7'($urandom);
    d.pr1       = 7'($urandom_range(0, 7));
    d.pr1_ready = 1'($urandom_range(0, 1));
    d.pr2       = 7'($urandom_range(0, 7));
    d.pr2_ready = 1'($urandom_range(0, 1));
    d.imm       = $urandom;
    d.rob_index = 5'($urandom);
    return d;
  endfunction

  function automatic dispatch_pipeline_data mk_instr(input logic [6:0] p1, input bit r1,
                                                     input logic [6:0] p2, input bit r2,
                                                     input logic [6:0] prd);
    dispatch_pipeline_data d = rand_instr();
    d.pr1 = p1; d.pr1_ready = r1;
    d.pr2 = p2; d.pr2_ready = r2;
    d.prd = prd;
    return d;
  endfunction

  task automatic step(input bit rst, input bit dv, input logic [1:0] fu,
                      input dispatch_pipeline_data d, input bit wv, input logic [6:0] wp,
                      input bit fl, input bit ir);
    int p, cnt, free;
    bit exp_iv, acc;
    rs_data exp_data;
    @(negedge clk);
    reset             = rst;
    rs_if.disp_valid  = dv;
    rs_if.disp_fu     = fu;
    rs_if.disp_data   = d;
    rs_if.wb_valid    = wv;
    rs_if.wb_prd      = wp;
    rs_if.flush       = fl;
    rs_if.issue_ready = ir;
    #1;
    p      = m_pick();
    cnt    = m_count();
    exp_iv = !rst && (p >= 0);
    exp_data = '0;
    if (exp_iv) exp_data = m_view(p);
    check_eq("issue_valid", 128'(rs_if.issue_valid), 128'(exp_iv));
    check_eq("issue_data", 128'(rs_if.issue_data), 128'(exp_data));
    check_eq("full", 128'(rs_if.full), 128'(!rst && cnt == DEPTH));
    check_eq("disp_ready", 128'(rs_if.disp_ready), 128'(rst || cnt < DEPTH));

    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m[i].v = 1'b0; m[i].age = 0; end
    end else if (fl) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
    end else begin
      acc  = dv && (fu == FU_ID) && (cnt < DEPTH);
      free = -1;
      for (int i = 0; i < DEPTH; i++) if (!m[i].v && free < 0) free = i;
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].v) begin
          if (wv && m[i].d.pr1 == wp) m[i].d.pr1_ready = 1'b1;
          if (wv && m[i].d.pr2 == wp) m[i].d.pr2_ready = 1'b1;
          if (acc && m[i].age < 7) m[i].age++;
        end
      end
      if (exp_iv && ir) m[p].v = 1'b0;
      if (acc) begin
        m[free].v   = 1'b1;
        m[free].age = 0;
        m[free].d   = d;
        m[free].d.pr1_ready = d.pr1_ready || d.pr1 == 0 || (wv && d.pr1 == wp);
        m[free].d.pr2_ready = d.pr2_ready || d.pr2 == 0 || (wv && d.pr2 == wp);
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, FU_ID, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit ir);
    step(1'b0, 1'b0, FU_ID, '0, 1'b0, '0, 1'b0, ir);
  endtask

  task automatic disp(input dispatch_pipeline_data d, input bit ir);
    step(1'b0, 1'b1, FU_ID, d, 1'b0, '0, 1'b0, ir);
  endtask

  initial begin
    reset             = 1'b1;
    rs_if.disp_valid  = 1'b0;
    rs_if.disp_fu     = FU_ID;
    rs_if.disp_data   = '0;
    rs_if.wb_valid    = 1'b0;
    rs_if.wb_prd      = '0;
    rs_if.flush       = 1'b0;
    rs_if.issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m[i].v = 1'b0; m[i].age = 0; m[i].d = '0; end

    do_reset();
    do_reset();
    idle(1'b0);
    check_eq("rst_issue_valid", 128'(rs_if.issue_valid), 128'(0));
    check_eq("rst_disp_ready", 128'(rs_if.disp_ready), 128'(1));

    // Late wakeup of pr2 releases the entry one cycle after the broadcast.
    do_reset();
    disp(mk_instr(7'd5, 1'b1, 7'd6, 1'b0, 7'd10), 1'b1);
    idle(1'b1);
    check_eq("req037_wait", 128'(rs_if.issue_valid), 128'(0));
    step(1'b0, 1'b0, FU_ID, '0, 1'b1, 7'd6, 1'b0, 1'b1);
    check_eq("req037_wait2", 128'(rs_if.issue_valid), 128'(0));
    idle(1'b1);
    check_eq("req037_valid", 128'(rs_if.issue_valid), 128'(1));
    check_eq("req037_prd", 128'(rs_if.issue_data.prd), 128'(7'd10));

    // Fill, drop the ninth, then drain in dispatch order.
    do_reset();
    for (int k = 0; k < DEPTH; k++) disp(mk_instr(7'd0, 1'b0, 7'd0, 1'b0, 7'(20 + k)), 1'b0);
    disp(mk_instr(7'd0, 1'b1, 7'd0, 1'b1, 7'd99), 1'b0);
    check_eq("req038_full", 128'(rs_if.full), 128'(1));
    check_eq("req038_disp_ready", 128'(rs_if.disp_ready), 128'(0));
    for (int k = 0; k < DEPTH; k++) begin
      idle(1'b1);
      check_eq("req038_order", 128'(rs_if.issue_data.prd), 128'(7'(20 + k)));
    end
    idle(1'b1);
    check_eq("req038_empty", 128'(rs_if.issue_valid), 128'(0));

    // Younger ready entry bypasses an older waiting one.
    do_reset();
    disp(mk_instr(7'd7, 1'b0, 7'd0, 1'b0, 7'd30), 1'b1);
    disp(mk_instr(7'd0, 1'b0, 7'd0, 1'b0, 7'd31), 1'b1);
    step(1'b0, 1'b0, FU_ID, '0, 1'b1, 7'd7, 1'b0, 1'b1);
    check_eq("req039_b", 128'(rs_if.issue_data.prd), 128'(7'd31));
    idle(1'b1);
    check_eq("req039_a_valid", 128'(rs_if.issue_valid), 128'(1));
    check_eq("req039_a", 128'(rs_if.issue_data.prd), 128'(7'd30));

    // Same-cycle broadcast bypass on insert.
    do_reset();
    step(1'b0, 1'b1, FU_ID, mk_instr(7'd9, 1'b0, 7'd0, 1'b0, 7'd40), 1'b1, 7'd9, 1'b0, 1'b1);
    idle(1'b1);
    check_eq("req040_valid", 128'(rs_if.issue_valid), 128'(1));
    check_eq("req040_prd", 128'(rs_if.issue_data.prd), 128'(7'd40));

    // Flush with a concurrent dispatch leaves nothing behind.
    do_reset();
    for (int k = 0; k < 5; k++) disp(rand_instr(), 1'b0);
    step(1'b0, 1'b1, FU_ID, mk_instr(7'd0, 1'b1, 7'd0, 1'b1, 7'd50), 1'b0, '0, 1'b1, 1'b1);
    idle(1'b1);
    check_eq("req041_valid", 128'(rs_if.issue_valid), 128'(0));
    check_eq("req041_full", 128'(rs_if.full), 128'(0));
    idle(1'b1);
    check_eq("req041_empty", 128'(rs_if.issue_valid), 128'(0));

    // Foreign FU code is ignored.
    do_reset();
    step(1'b0, 1'b1, FU_MEM, mk_instr(7'd0, 1'b1, 7'd0, 1'b1, 7'd60), 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("req042_valid", 128'(rs_if.issue_valid), 128'(0));
    idle(1'b0);
    check_eq("req042_valid2", 128'(rs_if.issue_valid), 128'(0));

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : FU_ID,
           rand_instr(),
           1'($urandom_range(0, 1)),
           7'($urandom_range(0, 7)),
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter DEPTH, default 8: number of entries; the design is verified at 8 only.
REQ-002 Parameter FU_ID, default 2'd0: functional-unit code this instance accepts (0=ALU, 1=BR, 2=MEM).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 disp_valid  input  1  dispatch stage presents an instruction.
REQ-006 disp_fu  input  2  FU code of the presented instruction.
REQ-007 disp_data  input  dispatch_pipeline_data  Opcode, pc, prd, pr1/pr1_ready, pr2/pr2_ready, imm, rob_index.
REQ-008 disp_ready  output  1  at least one free entry.
REQ-009 wb_valid  input  1  result broadcast valid (wakeup).
REQ-010 wb_prd  input  7  physical register being written.
REQ-011 flush  input  1  mispredict; discard all entries.
REQ-012 issue_valid  output  1  a ready entry is presented.
REQ-013 issue_ready  input  1  FU accepts the presented entry.
REQ-014 issue_data  output  rs_data  selected entry.
REQ-015 full  output  1  all DEPTH entries valid.

Function
REQ-016 Accept: disp_valid && disp_ready && disp_fu==FU_ID && !flush writes the lowest-index free entry; valid=1, fu=disp_fu, age=0; other fields copied from disp_data.
REQ-017 disp_ready = !full, computed from registered valid bits only; a same-cycle issue does not free a slot for a same-cycle dispatch.
REQ-018 disp_valid with disp_fu!=FU_ID is ignored; no state change.
REQ-019 Wakeup: wb_valid sets pr1_ready (pr2_ready) in every valid entry whose pr1 (pr2) == wb_prd, at the next edge.
REQ-020 Wakeup bypass on insert: when the entry being written has pr1 or pr2 == wb_prd and wb_valid, the corresponding ready bit is written as 1.
REQ-021 Physical register 0 is always ready; pr1/pr2 == 0 forces the ready bit to 1 on insert.
REQ-022 Eligible entry: valid && pr1_ready && pr2_ready, evaluated from registered state; wakeup and insert take effect for selection the following cycle.
REQ-023 Dispatch-to-issue latency: minimum one cycle (accepted at edge N, issue_valid can be 1 in cycle N+1).
REQ-024 Select: among eligible entries, highest age wins; ties go to the lowest index; issue_valid = any eligible; issue_data = selected entry (zeros when issue_valid=0).
REQ-025 Issue handshake: entry is cleared (valid=0) at the edge where issue_valid && issue_ready; with issue_ready=0 the same entry stays presented, stable, unless an older one becomes eligible.
REQ-026 Aging: on each accepted dispatch, every other valid entry increments age, saturating at 7.
REQ-027 Simultaneous issue and dispatch to different entries are both performed in the same cycle.
REQ-028 Simultaneous wakeup and issue of the same entry: the issue wins and the entry is removed.
REQ-029 flush: all valid bits clear at the next edge; dispatch and issue handshakes in that cycle have no effect on state; issue_valid is still driven combinationally that cycle, and the FU discards it.
REQ-030 full = all DEPTH valid bits set; empty state yields issue_valid=0.

Reset
REQ-031 reset=1 at an edge clears all valid bits, ages and ready bits; it overrides flush, dispatch, wakeup and issue.
REQ-032 Outputs during and after reset: disp_ready=1, full=0, issue_valid=0, issue_data=0.
REQ-033 Reset asserted mid-operation discards all entries with no issue generated.

Structure
REQ-034 rs_data, dispatch_pipeline_data and the FU code constants (FU_ALU=0, FU_BR=1, FU_MEM=2) live in types_pkg.
REQ-035 The oldest-ready picker is a sub-module rs_select: input eligible vector + ages, output one-hot grant + valid.
REQ-036 Entry storage is a flat array of rs_data registers; no RAM macros.

Verification
REQ-037 Reset, then dispatch pr1=5 (rdy), pr2=6 (not rdy), prd=10; wb_prd=6 at cycle 3 -> issue_valid=1 in cycle 4 with prd=10.
REQ-038 Dispatch 8 entries, all with pr1=pr2=0 and issue_ready=0 -> full=1, disp_ready=0 and a 9th dispatch is dropped; issue_ready=1 -> entries issue in dispatch order, index 0 first.
REQ-039 Entries A (older, waiting on p7) and B (ready) -> B issues; wb_prd=7 -> A issues the next cycle.
REQ-040 Dispatch pr1=9 while wb_valid=1, wb_prd=9 in the same cycle -> entry is ready; issue_valid=1 the next cycle.
REQ-041 Fill 5 entries, assert flush with concurrent disp_valid -> the next cycle issue_valid=0, full=0, and no entry remains.
REQ-042 disp_fu=MEM into FU_ID=ALU instance -> no entry written, issue_valid stays 0.
